// File: rtl/ast_sa_pkg.sv
// Shared constants, FSM state encoding and drain-length helper for the systolic array sequencer.
package ast_sa_pkg;

    localparam int DATAWIDTH = 16;
    localparam int DIM       = 4;
    localparam int MAC_LAT   = 1;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        CLEAR = 3'd1,
        FEED  = 3'd2,
        DRAIN = 3'd3,
        DONE  = 3'd4
    } state_e;

    // Skew spreads the last beat over 2*(DIM-1) extra hops before the far corner PE sees it.
    function automatic int drain_cyc(input int dim, input int mac_lat);
        return 2 * (dim - 1) + mac_lat + 1;
    endfunction

endpackage

// File: rtl/ast_skew_buf_v.sv
// Per-lane delay lines: lane l of din appears on dout lane l after l+1 cycles.
module ast_skew_buf_v #(
    parameter int DATAWIDTH = ast_sa_pkg::DATAWIDTH,
    parameter int DIM       = ast_sa_pkg::DIM
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     din_vld,
    input  logic [DIM*DATAWIDTH-1:0] din,
    output logic [DIM*DATAWIDTH-1:0] dout
);

    for (genvar lane = 0; lane < DIM; lane++) begin : g_lane
        logic [DATAWIDTH-1:0] pipe [lane+1];

        // An invalid beat enters as zero so it contributes nothing to the dot products.
        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                for (int d = 0; d <= lane; d++) begin
                    pipe[d] <= '0;
                end
            end else begin
                pipe[0] <= din_vld ? din[lane*DATAWIDTH +: DATAWIDTH] : '0;
                for (int d = 1; d <= lane; d++) begin
                    pipe[d] <= pipe[d-1];
                end
            end
        end

        assign dout[lane*DATAWIDTH +: DATAWIDTH] = pipe[lane];
    end

endmodule

// File: rtl/ast_systolic_ctrl_v.sv
// Sequencer for the DIM x DIM systolic MAC array: clear, feed K skewed beats, drain, pulse done.
// Optional stall counter enabled by defining AST_CTRL_PERF_EN.
module ast_systolic_ctrl_v #(
    parameter int DATAWIDTH = ast_sa_pkg::DATAWIDTH,
    parameter int DIM       = ast_sa_pkg::DIM,
    parameter int K_W       = 8,
    parameter int MAC_LAT   = ast_sa_pkg::MAC_LAT
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     start,
    input  logic [K_W-1:0]           k_len,
    input  logic                     op_vld,
    output logic                     op_rdy,
    input  logic [DIM*DATAWIDTH-1:0] a_vec,
    input  logic [DIM*DATAWIDTH-1:0] b_vec,
    output logic [DIM*DATAWIDTH-1:0] a_skew,
    output logic [DIM*DATAWIDTH-1:0] b_skew,
    output logic                     mult_en,
    output logic                     acc_en,
    output logic                     load_en,
    output logic                     busy,
    output logic                     done,
    output logic [15:0]              stall_cnt
);

    import ast_sa_pkg::*;

    localparam int DRAIN_CYC = drain_cyc(DIM, MAC_LAT);
    localparam int DC_W      = $clog2(DRAIN_CYC + 1);

    localparam logic [2:0] ST_IDLE  = IDLE;
    localparam logic [2:0] ST_CLEAR = CLEAR;
    localparam logic [2:0] ST_FEED  = FEED;
    localparam logic [2:0] ST_DRAIN = DRAIN;
    localparam logic [2:0] ST_DONE  = DONE;

    logic [2:0]      state;
    logic [K_W-1:0]  k_reg;
    logic [K_W-1:0]  beat_cnt;
    logic [DC_W-1:0] drain_cnt;
    logic            beat_acc;
    logic            last_beat;

    assign op_rdy    = (state == ST_FEED);
    assign beat_acc  = op_vld && op_rdy;
    assign last_beat = (beat_cnt == k_reg - K_W'(1));
    assign mult_en   = (state == ST_FEED) || (state == ST_DRAIN);
    assign acc_en    = mult_en;
    assign load_en   = (state == ST_CLEAR);
    assign busy      = (state != ST_IDLE);
    assign done      = (state == ST_DONE);

    // beat_cnt stops at k_reg-1, so K = 2**K_W-1 never wraps it.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= ST_IDLE;
            k_reg     <= '0;
            beat_cnt  <= '0;
            drain_cnt <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        k_reg <= k_len;
                        state <= ST_CLEAR;
                    end
                end
                ST_CLEAR: begin
                    beat_cnt  <= '0;
                    drain_cnt <= '0;
                    state     <= (k_reg == '0) ? ST_DONE : ST_FEED;
                end
                ST_FEED: begin
                    if (beat_acc) begin
                        if (last_beat) begin
                            state <= ST_DRAIN;
                        end else begin
                            beat_cnt <= beat_cnt + K_W'(1);
                        end
                    end
                end
                ST_DRAIN: begin
                    if (drain_cnt == DC_W'(DRAIN_CYC - 1)) begin
                        state <= ST_DONE;
                    end else begin
                        drain_cnt <= drain_cnt + DC_W'(1);
                    end
                end
                ST_DONE: state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

    ast_skew_buf_v #(.DATAWIDTH(DATAWIDTH), .DIM(DIM)) u_a_skew (
        .clk     (clk),
        .reset   (reset),
        .din_vld (beat_acc),
        .din     (a_vec),
        .dout    (a_skew)
    );

    ast_skew_buf_v #(.DATAWIDTH(DATAWIDTH), .DIM(DIM)) u_b_skew (
        .clk     (clk),
        .reset   (reset),
        .din_vld (beat_acc),
        .din     (b_vec),
        .dout    (b_skew)
    );

`ifdef AST_CTRL_PERF_EN
    logic [15:0] stall_q;

    // Saturates so a pathologically stalled job still reads as "very slow", not small.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stall_q <= '0;
        end else if (state == ST_CLEAR) begin
            stall_q <= '0;
        end else if (state == ST_FEED && !op_vld && stall_q != 16'hFFFF) begin
            stall_q <= stall_q + 16'd1;
        end
    end

    assign stall_cnt = stall_q;
`else
    assign stall_cnt = 16'd0;
`endif

endmodule
